// File: rtl/jtag_host_shifter.sv
// Host-side JTAG initiator: runs TAP reset / IR scan / DR scan / idle-clock commands from CLK.
// Define JTAG_TDO_CHECK_EN to add the cmd_expect / rsp_mismatch TDO compare.
module jtag_host_shifter #(
  parameter int MAX_LEN = 32,
  parameter int CLK_DIV = 2
) (
  input  logic                         CLK,
  input  logic                         TRST,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [$clog2(MAX_LEN+1)-1:0] cmd_len,
  input  logic [MAX_LEN-1:0]           cmd_data,
`ifdef JTAG_TDO_CHECK_EN
  input  logic [MAX_LEN-1:0]           cmd_expect,
  output logic                         rsp_mismatch,
`endif
  output logic                         rsp_valid,
  output logic [MAX_LEN-1:0]           rsp_data,
  output logic                         TCK,
  output logic                         TMS,
  output logic                         TDI,
  input  logic                         TDO
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [1:0] OP_RST  = 2'b00;
  localparam logic [1:0] OP_IR   = 2'b01;
  localparam logic [1:0] OP_DR   = 2'b10;
  localparam logic [1:0] OP_IDLE = 2'b11;

  // TMS lead-in sequences, LSB first
  localparam logic [5:0] SEQ_RST = 6'b011111;
  localparam logic [5:0] SEQ_IR  = 6'b000011;
  localparam logic [5:0] SEQ_DR  = 6'b000001;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SHIFT, S_POST, S_DONE} state_t;

  function automatic logic pre_tms(input logic [1:0] op, input logic [5:0] idx);
    logic [5:0] s;
    case (op)
      OP_RST:  s = SEQ_RST >> idx;
      OP_IR:   s = SEQ_IR >> idx;
      OP_DR:   s = SEQ_DR >> idx;
      default: s = 6'b000000;
    endcase
    return s[0];
  endfunction

  function automatic logic [5:0] pre_last(input logic [1:0] op);
    case (op)
      OP_RST:  return 6'd5;
      OP_IR:   return 6'd3;
      OP_DR:   return 6'd2;
      default: return 6'd0;
    endcase
  endfunction

  state_t             state_q, state_d;
  logic [1:0]         op_q;
  logic [LW-1:0]      len_q;
  logic [MAX_LEN-1:0] data_q;
  logic [DW-1:0]      div_q, div_d;
  logic               tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic [5:0]         pulse_q, pulse_d;
  logic [LW-1:0]      bit_q, bit_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic               rsp_valid_q, ready_q;
  logic [MAX_LEN-1:0] rsp_data_q;

  logic               accept;
  logic               empty;
  logic               last_phase;
  logic [LW-1:0]      len_clamped;
  logic [LW-1:0]      next_bit;
  logic [MAX_LEN-1:0] shifted;

  assign accept      = cmd_valid && ready_q;
  assign len_clamped = (cmd_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cmd_len;
  assign empty       = (op_q != OP_RST) && (len_q == '0);
  assign last_phase  = (div_q == DW'(CLK_DIV - 1));
  assign next_bit    = bit_q + LW'(1);
  assign shifted     = data_q >> next_bit;

  // Next-state, TCK phase sequencing and TMS/TDI selection
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    tck_d   = tck_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    pulse_d = pulse_q;
    bit_d   = bit_q;
    cap_d   = cap_q;
    case (state_q)
      S_IDLE: begin
        tck_d = 1'b0;
        if (cmd_valid) begin
          state_d = S_PRE;
          div_d   = '0;
          pulse_d = 6'd0;
          bit_d   = '0;
          cap_d   = '0;
          // Zero-length scans produce no pulse, so leave TMS/TDI alone
          if ((cmd_op == OP_RST) || (len_clamped != '0)) begin
            tms_d = (cmd_op != OP_IDLE);
            tdi_d = 1'b0;
          end else begin
            tms_d = tms_q;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRE, S_SHIFT, S_POST: begin
        if ((state_q == S_PRE) && empty) begin
          state_d = S_DONE;
        end else if (!last_phase) begin
          div_d = div_q + DW'(1);
        end else if (!tck_q) begin
          div_d = '0;
          tck_d = 1'b1;
          if (state_q == S_SHIFT) begin
            cap_d = cap_q | (MAX_LEN'(TDO) << bit_q);
          end else begin
            cap_d = cap_q;
          end
        end else begin
          div_d = '0;
          tck_d = 1'b0;
          case (state_q)
            S_PRE: begin
              if (op_q == OP_IDLE) begin
                if (next_bit < len_q) begin
                  bit_d = next_bit;
                  tms_d = 1'b0;
                end else begin
                  state_d = S_DONE;
                end
              end else if (pulse_q != pre_last(op_q)) begin
                pulse_d = pulse_q + 6'd1;
                tms_d   = pre_tms(op_q, pulse_q + 6'd1);
              end else if (op_q == OP_RST) begin
                state_d = S_DONE;
              end else begin
                state_d = S_SHIFT;
                bit_d   = '0;
                tms_d   = (len_q == LW'(1));
                tdi_d   = data_q[0];
              end
            end
            S_SHIFT: begin
              if (next_bit < len_q) begin
                bit_d = next_bit;
                tms_d = (next_bit == (len_q - LW'(1)));
                tdi_d = shifted[0];
              end else begin
                state_d = S_POST;
                pulse_d = 6'd0;
                tms_d   = 1'b1;
                tdi_d   = 1'b0;
              end
            end
            default: begin
              if (pulse_q == 6'd0) begin
                pulse_d = 6'd1;
                tms_d   = 1'b0;
              end else begin
                state_d = S_DONE;
              end
            end
          endcase
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, pin drivers and response registers
  always_ff @(posedge CLK or negedge TRST) begin
    if (!TRST) begin
      state_q     <= S_IDLE;
      op_q        <= 2'b00;
      len_q       <= '0;
      data_q      <= '0;
      div_q       <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      pulse_q     <= 6'd0;
      bit_q       <= '0;
      cap_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      pulse_q     <= pulse_d;
      bit_q       <= bit_d;
      cap_q       <= cap_d;
      ready_q     <= (state_d == S_IDLE);
      rsp_valid_q <= (state_d == S_DONE);
      if (accept) begin
        op_q   <= cmd_op;
        len_q  <= len_clamped;
        data_q <= cmd_data;
      end
      if (state_d == S_DONE) begin
        rsp_data_q <= cap_d;
      end
    end
  end

`ifdef JTAG_TDO_CHECK_EN
  logic [MAX_LEN-1:0] expect_q;
  logic               mismatch_q;
  logic [MAX_LEN-1:0] lenmask;

  assign lenmask = ~({MAX_LEN{1'b1}} << len_q);

  // Expected-TDO capture and compare, flagged alongside rsp_valid
  always_ff @(posedge CLK or negedge TRST) begin
    if (!TRST) begin
      expect_q   <= '0;
      mismatch_q <= 1'b0;
    end else begin
      if (accept) begin
        expect_q <= cmd_expect;
      end
      mismatch_q <= (state_d == S_DONE) && (|((cap_d ^ expect_q) & lenmask));
    end
  end

  assign rsp_mismatch = mismatch_q;
`endif

  assign cmd_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign TCK       = tck_q;
  assign TMS       = tms_q;
  assign TDI       = tdi_q;
endmodule

// File: tb/tb_jtag_host_shifter.sv
// Directed-vector bench for jtag_host_shifter with a behavioural TAP (bypass DR, 5-bit IR).
module tb_jtag_host_shifter;
  logic        clk = 1'b0;
  logic        trst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [5:0]  cmd_len = 6'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        cmd_ready, rsp_valid, tck, tms, tdi;
  logic [31:0] rsp_data;
  logic        c3_valid = 1'b0;
  logic [1:0]  c3_op = 2'b00;
  logic [5:0]  c3_len = 6'd0;
  logic [31:0] c3_data = 32'd0;
  logic        c3_ready, c3_rsp_valid, c3_tck, c3_tms, c3_tdi;
  logic [31:0] c3_rsp_data;
`ifdef JTAG_TDO_CHECK_EN
  logic        mism, c3_mism;
`endif

  int n_cmp = 0;
  int n_miscmp = 0;

  always #5 clk = ~clk;

  // TAP model
  typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUDR, EX2DR, UPDR,
                            SELIR, CAPIR, SHIR, EX1IR, PAUIR, EX2IR, UPIR} tap_t;
  tap_t       tap_q = TLR;
  logic       byp_q = 1'b0;
  logic [4:0] irsr_q = 5'd0;
  logic [4:0] ir_q = 5'b00001;
  logic       tdo_r = 1'b0;

  always @(posedge tck) begin
    case (tap_q)
      CAPDR:   byp_q <= 1'b0;
      SHDR:    byp_q <= tdi;
      CAPIR:   irsr_q <= 5'b00001;
      SHIR:    irsr_q <= {tdi, irsr_q[4:1]};
      default: ;
    endcase
    case (tap_q)
      TLR:     tap_q <= tms ? TLR   : RTI;
      RTI:     tap_q <= tms ? SELDR : RTI;
      SELDR:   tap_q <= tms ? SELIR : CAPDR;
      CAPDR:   tap_q <= tms ? EX1DR : SHDR;
      SHDR:    tap_q <= tms ? EX1DR : SHDR;
      EX1DR:   tap_q <= tms ? UPDR  : PAUDR;
      PAUDR:   tap_q <= tms ? EX2DR : PAUDR;
      EX2DR:   tap_q <= tms ? UPDR  : SHDR;
      UPDR:    tap_q <= tms ? SELDR : RTI;
      SELIR:   tap_q <= tms ? TLR   : CAPIR;
      CAPIR:   tap_q <= tms ? EX1IR : SHIR;
      SHIR:    tap_q <= tms ? EX1IR : SHIR;
      EX1IR:   tap_q <= tms ? UPIR  : PAUIR;
      PAUIR:   tap_q <= tms ? EX2IR : PAUIR;
      EX2IR:   tap_q <= tms ? UPIR  : SHIR;
      default: tap_q <= tms ? SELDR : RTI;
    endcase
  end

  always @(negedge tck) begin
    if (tap_q == SHDR) tdo_r <= byp_q;
    else if (tap_q == SHIR) tdo_r <= irsr_q[0];
    if (tap_q == UPIR) ir_q <= irsr_q;
    else if (tap_q == TLR) ir_q <= 5'b00001;
  end

  // Pulse monitor: TMS/TDI seen at each TCK rise, and any change while TCK is high
  int   npulse = 0;
  int   viol = 0;
  logic tms_log [0:2047];
  logic tdi_log [0:2047];
  logic tms_rise = 1'b0, tdi_rise = 1'b0;

  always @(posedge tck) begin
    if (npulse < 2048) begin
      tms_log[npulse] = tms;
      tdi_log[npulse] = tdi;
    end
    tms_rise = tms;
    tdi_rise = tdi;
    npulse++;
  end

  always @(negedge clk) begin
    if (trst && tck && ((tms !== tms_rise) || (tdi !== tdi_rise))) viol++;
  end

  jtag_host_shifter #(.MAX_LEN(32), .CLK_DIV(2)) dut (
    .CLK(clk), .TRST(trst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
`ifdef JTAG_TDO_CHECK_EN
    .cmd_expect(32'd0), .rsp_mismatch(mism),
`endif
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .TCK(tck), .TMS(tms), .TDI(tdi), .TDO(tdo_r)
  );

  jtag_host_shifter #(.MAX_LEN(32), .CLK_DIV(3)) dut3 (
    .CLK(clk), .TRST(trst), .cmd_valid(c3_valid), .cmd_ready(c3_ready),
    .cmd_op(c3_op), .cmd_len(c3_len), .cmd_data(c3_data),
`ifdef JTAG_TDO_CHECK_EN
    .cmd_expect(32'd0), .rsp_mismatch(c3_mism),
`endif
    .rsp_valid(c3_rsp_valid), .rsp_data(c3_rsp_data),
    .TCK(c3_tck), .TMS(c3_tms), .TDI(c3_tdi), .TDO(1'b0)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  len;
    logic [31:0] data;
    int          pulses;
    int          lat;
    logic [63:0] tms;
    logic [63:0] tdi;
    logic [63:0] tdi_mask;
    logic [31:0] rsp;
    logic        chk_ir;
    logic [4:0]  ir;
  } vec_t;

  vec_t vecs [7];

  task automatic run_vec(input int idx, input vec_t v);
    int base, lat, nvalid, nhigh, cnt;
    logic ready_after, valid_after;
    logic [31:0] rsp_at_lat, rsp_end;
    logic [63:0] tms_v, tdi_v;
    base = npulse;
    lat = 0; nvalid = 0; nhigh = 0;
    ready_after = 1'b0; valid_after = 1'b1;
    rsp_at_lat = 32'd0; rsp_end = 32'd0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = v.op; cmd_len = v.len; cmd_data = v.data;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk($sformatf("v%0d ready_drop", idx), 64'(cmd_ready), 64'd0);
    for (int k = 1; k <= v.lat + 4; k++) begin
      if (k > 1) @(negedge clk);
      if (tck) nhigh++;
      if (rsp_valid) begin
        nvalid++;
        if (lat == 0) begin
          lat = k;
          rsp_at_lat = rsp_data;
        end
      end
      if ((lat != 0) && (k == lat + 1)) begin
        ready_after = cmd_ready;
        valid_after = rsp_valid;
      end
      rsp_end = rsp_data;
    end
    cnt = npulse - base;
    tms_v = 64'd0; tdi_v = 64'd0;
    for (int i = 0; i < 64; i++) begin
      if (i < cnt) begin
        tms_v[i] = tms_log[base + i];
        tdi_v[i] = tdi_log[base + i];
      end
    end
    chk($sformatf("v%0d latency", idx), 64'(lat), 64'(v.lat));
    chk($sformatf("v%0d rsp_valid_count", idx), 64'(nvalid), 64'd1);
    chk($sformatf("v%0d rsp_data", idx), 64'(rsp_at_lat), 64'(v.rsp));
    chk($sformatf("v%0d rsp_hold", idx), 64'(rsp_end), 64'(v.rsp));
    chk($sformatf("v%0d ready_return", idx), 64'(ready_after), 64'd1);
    chk($sformatf("v%0d valid_single", idx), 64'(valid_after), 64'd0);
    chk($sformatf("v%0d pulses", idx), 64'(cnt), 64'(v.pulses));
    chk($sformatf("v%0d tck_high_cycles", idx), 64'(nhigh), 64'(v.pulses * 2));
    chk($sformatf("v%0d tms_seq", idx), tms_v, v.tms);
    chk($sformatf("v%0d tdi_shift", idx), tdi_v & v.tdi_mask, v.tdi);
    chk($sformatf("v%0d tap_rti", idx), 64'(tap_q), 64'(RTI));
    if (v.chk_ir) chk($sformatf("v%0d ir_value", idx), 64'(ir_q), 64'(v.ir));
  endtask

  initial begin
    int base, k, nvalid, nhigh;
    //          op     len    data           pls lat  tms                    tdi                    tdi_mask               rsp            ir?   ir
    vecs[0] = '{2'b00, 6'd0,  32'h0000_0000, 6,  25,  64'h0000_0000_0000_001F, 64'h0, 64'h0,                           32'h0000_0000, 1'b0, 5'd0};
    vecs[1] = '{2'b10, 6'd4,  32'h0000_000B, 9,  37,  64'h0000_0000_0000_00C1, 64'h058, 64'h078,                       32'h0000_0006, 1'b0, 5'd0};
    vecs[2] = '{2'b01, 6'd5,  32'h0000_0015, 11, 45,  64'h0000_0000_0000_0303, 64'h150, 64'h1F0,                       32'h0000_0001, 1'b1, 5'h15};
    vecs[3] = '{2'b10, 6'd0,  32'hFFFF_FFFF, 0,  2,   64'h0, 64'h0, 64'h0,                                             32'h0000_0000, 1'b1, 5'h15};
    vecs[4] = '{2'b11, 6'd3,  32'hFFFF_FFFF, 3,  13,  64'h0, 64'h0, 64'h7,                                             32'h0000_0000, 1'b0, 5'd0};
    vecs[5] = '{2'b10, 6'd40, 32'hA5A5_A5A5, 37, 149, 64'h0000_000C_0000_0001, 64'h0000_0005_2D2D_2D28, 64'h0000_0007_FFFF_FFF8, 32'h4B4B_4B4A, 1'b0, 5'd0};
    vecs[6] = '{2'b10, 6'd1,  32'h0000_0001, 6,  25,  64'h0000_0000_0000_0019, 64'h008, 64'h008,                       32'h0000_0000, 1'b0, 5'd0};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_tck", 64'(tck), 64'd0);
    chk("rst_tms", 64'(tms), 64'd1);
    chk("rst_tdi", 64'(tdi), 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_data", 64'(rsp_data), 64'd0);
    trst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Abort an 8-bit DR scan during shift bit 2
    base = npulse;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 6'd8; cmd_data = 32'h0000_00C3;
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 0;
    while ((npulse < base + 6) && (k < 200)) begin
      @(negedge clk);
      k++;
    end
    chk("abort_reached_bit2", 64'(npulse - base), 64'd6);
    trst = 1'b0;
    nvalid = 0;
    for (int j = 0; j < 4; j++) begin
      #1;
      chk($sformatf("abort_tck_%0d", j), 64'(tck), 64'd0);
      chk($sformatf("abort_tms_%0d", j), 64'(tms), 64'd1);
      chk($sformatf("abort_tdi_%0d", j), 64'(tdi), 64'd0);
      chk($sformatf("abort_ready_%0d", j), 64'(cmd_ready), 64'd1);
      if (rsp_valid) nvalid++;
      @(negedge clk);
    end
    trst = 1'b1;
    nhigh = 0;
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      if (rsp_valid) nvalid++;
      if (tck) nhigh++;
    end
    chk("abort_no_rsp", 64'(nvalid), 64'd0);
    chk("abort_no_tck", 64'(nhigh), 64'd0);
    run_vec(7, vecs[0]);

    // CLK_DIV=3 idle clocks, len 3
    @(negedge clk);
    c3_valid = 1'b1; c3_op = 2'b11; c3_len = 6'd3; c3_data = 32'd0;
    @(negedge clk);
    c3_valid = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      if (j > 1) @(negedge clk);
      chk($sformatf("d3_tck_k%0d", j), 64'(c3_tck), 64'((j <= 18) && (((j - 1) % 6) >= 3)));
      chk($sformatf("d3_tms_k%0d", j), 64'(c3_tms), 64'd0);
      chk($sformatf("d3_valid_k%0d", j), 64'(c3_rsp_valid), 64'(j == 19));
    end
    chk("d3_ready_return", 64'(c3_ready), 64'd1);

    chk("tms_tdi_stable_high", 64'(viol), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miscmp);
    $finish;
  end
endmodule
